// File: rtl/bs_1_comp1_if.sv
// Serial operand/result bundle for the bit-serial comparator bs_1_comp1.
// The master drives the operand bit stream; the slave returns the registered LT/EQ/GT result.
interface bs_1_comp1_if;
  logic a;
  logic b;
  logic in_valid;
  logic in_first;
  logic in_last;
  logic LT;
  logic EQ;
  logic GT;
  logic out_valid;

  modport master (
    output a, b, in_valid, in_first, in_last,
    input  LT, EQ, GT, out_valid
  );

  modport slave (
    input  a, b, in_valid, in_first, in_last,
    output LT, EQ, GT, out_valid
  );
endinterface

// File: rtl/bs_1_comp1.sv
// Bit-serial MSB-first magnitude comparator built from a single 1-bit compare cell.
// Define BS_COMP_SIGNED_EN to compare two's-complement words (MSB sense swapped on the first beat).
module bs_1_comp1 (
  input logic          clk,
  input logic          rst_n,
  bs_1_comp1_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state;
  logic   dec_lt;
  logic   dec_gt;
  logic   lt_bit;
  logic   gt_bit;
  logic   first_lt;
  logic   first_gt;
  logic   next_lt;
  logic   next_gt;
  logic   beat;

  always_comb begin
    lt_bit = ~bus.a & bus.b;
    gt_bit = bus.a & ~bus.b;
`ifdef BS_COMP_SIGNED_EN
    // The sign bit carries negative weight, so a set MSB means the smaller value.
    first_lt = gt_bit;
    first_gt = lt_bit;
`else
    first_lt = lt_bit;
    first_gt = gt_bit;
`endif
    beat    = bus.in_valid & (bus.in_first | (state == ACTIVE));
    next_lt = dec_lt;
    next_gt = dec_gt;
    if (bus.in_first) begin
      next_lt = first_lt;
      next_gt = first_gt;
    end else if (!dec_lt && !dec_gt) begin
      next_lt = lt_bit;
      next_gt = gt_bit;
    end
  end

  // The accumulator locks on the first differing bit; in_first restarts it in either state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dec_lt        <= 1'b0;
      dec_gt        <= 1'b0;
      bus.LT        <= 1'b0;
      bus.EQ        <= 1'b1;
      bus.GT        <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (beat) begin
        dec_lt <= next_lt;
        dec_gt <= next_gt;
        if (bus.in_last) begin
          bus.LT        <= next_lt;
          bus.GT        <= next_gt;
          bus.EQ        <= ~(next_lt | next_gt);
          bus.out_valid <= 1'b1;
          state         <= IDLE;
        end else begin
          state <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bs_1_comp1.sv
// Self-checking bench for bs_1_comp1: directed words plus randomized framed streams
// checked every cycle against an integer-level reference model.
module tb_bs_1_comp1;

  logic clk;
  logic rst_n;
  int   compareCount;
  int   mismatchCount;

  bs_1_comp1_if bus_if ();

  bs_1_comp1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: collects the word as integers and compares them when it ends.
  bit     modelActive;
  int     modelLen;
  longint modelA;
  longint modelB;
  bit     expLt;
  bit     expEq;
  bit     expGt;
  bit     expOv;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    modelActive = 1'b0;
    modelLen    = 0;
    modelA      = 0;
    modelB      = 0;
    expLt       = 1'b0;
    expEq       = 1'b1;
    expGt       = 1'b0;
    expOv       = 1'b0;
  endtask

  task automatic modelBeat(input bit ia, input bit ib, input bit iv, input bit ifi, input bit il);
    longint sa;
    longint sb;
    expOv = 1'b0;
    if (!iv) return;
    if (ifi) begin
      modelActive = 1'b1;
      modelA      = longint'(ia);
      modelB      = longint'(ib);
      modelLen    = 1;
    end else if (modelActive) begin
      modelA   = modelA * 2 + longint'(ia);
      modelB   = modelB * 2 + longint'(ib);
      modelLen = modelLen + 1;
    end else begin
      return;
    end
    if (il) begin
      sa = modelA;
      sb = modelB;
`ifdef BS_COMP_SIGNED_EN
      if (sa >= (longint'(1) << (modelLen - 1))) sa = sa - (longint'(1) << modelLen);
      if (sb >= (longint'(1) << (modelLen - 1))) sb = sb - (longint'(1) << modelLen);
`endif
      expLt       = (sa < sb);
      expEq       = (sa == sb);
      expGt       = (sa > sb);
      expOv       = 1'b1;
      modelActive = 1'b0;
    end
  endtask

  // One clock: check what the last edge produced, then drive the next inputs.
  task automatic applyStimulus(input bit ia, input bit ib, input bit iv, input bit ifi, input bit il);
    @(negedge clk);
    checkOutput("out_valid", 32'(bus_if.out_valid), 32'(expOv));
    checkOutput("lt_eq_gt", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'({expLt, expEq, expGt}));
    bus_if.a        = ia;
    bus_if.b        = ib;
    bus_if.in_valid = iv;
    bus_if.in_first = ifi;
    bus_if.in_last  = il;
    modelBeat(ia, ib, iv, ifi, il);
  endtask

  task automatic idleCycle();
    applyStimulus(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0,
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
  endtask

  task automatic sendWord(input int len, input logic [31:0] av, input logic [31:0] bv, input int gapMax);
    for (int i = len - 1; i >= 0; i--) begin
      if (i != len - 1) begin
        int gaps = $urandom_range(gapMax, 0);
        for (int g = 0; g < gaps; g++) idleCycle();
      end
      applyStimulus(av[i], bv[i], 1'b1, i == len - 1, i == 0);
    end
  endtask

  task automatic sendPartial(input int len, input logic [31:0] av, input logic [31:0] bv);
    for (int i = len - 1; i >= 0; i--)
      applyStimulus(av[i], bv[i], 1'b1, i == len - 1, 1'b0);
  endtask

  task automatic holdReset(input int cycles);
    @(negedge clk);
    checkOutput("pre_reset_ov", 32'(bus_if.out_valid), 32'(expOv));
    rst_n           = 1'b0;
    bus_if.in_valid = 1'b0;
    modelReset();
    for (int i = 1; i < cycles; i++) idleCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    compareCount    = 0;
    mismatchCount   = 0;
    rst_n           = 1'b0;
    bus_if.a        = 1'b0;
    bus_if.b        = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_first = 1'b0;
    bus_if.in_last  = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_result", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b010));
    checkOutput("reset_ov", 32'(bus_if.out_valid), 32'd0);
    rst_n = 1'b1;

    // One-bit words at 10-cycle spacing.
    sendWord(1, 32'd1, 32'd0, 0); idleCycle();
    checkOutput("bit_10_gt", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b001));
    repeat (8) idleCycle();
    sendWord(1, 32'd0, 32'd0, 0); idleCycle();
    checkOutput("bit_00_eq", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b010));
    repeat (8) idleCycle();
    sendWord(1, 32'd0, 32'd1, 0); idleCycle();
    checkOutput("bit_01_lt", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b100));
    repeat (8) idleCycle();
    sendWord(1, 32'd1, 32'd1, 0); idleCycle();
    checkOutput("bit_11_eq", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b010));
    repeat (8) idleCycle();

    // Four-bit words back to back.
    sendWord(4, 32'b1010, 32'b1001, 0);
    sendWord(4, 32'b0110, 32'b0110, 0);
    sendWord(4, 32'b0011, 32'b1000, 0);
    idleCycle();
    checkOutput("b2b_last_lt", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b100));
    repeat (3) idleCycle();

    // Restart mid-word: the aborted word must not produce out_valid.
    sendPartial(2, 32'b11, 32'b01);
    sendWord(2, 32'b00, 32'b01, 0);
    idleCycle();
    checkOutput("restart_lt", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b100));
    repeat (3) idleCycle();

    // Reset in the middle of a word, then a full word.
    sendPartial(2, 32'b10, 32'b01);
    holdReset(3);
    idleCycle();
    sendWord(4, 32'b0101, 32'b0100, 0);
    idleCycle();
    checkOutput("post_reset_gt", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b001));

    // Word with idle gaps between bits.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idleCycle(); idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycle(); idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idleCycle();
    checkOutput("gap_gt", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b001));
    checkOutput("gap_ov", 32'(bus_if.out_valid), 32'd1);
    idleCycle();

    // Sign-sensitive word: -8 vs 7 signed, 8 vs 7 unsigned.
    sendWord(4, 32'b1000, 32'b0111, 0);
    idleCycle();
`ifdef BS_COMP_SIGNED_EN
    checkOutput("sign_word", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b100));
`else
    checkOutput("sign_word", 32'({bus_if.LT, bus_if.EQ, bus_if.GT}), 32'(3'b001));
`endif

    // Randomized framing: whole words, aborted words and stray beats outside a word.
    for (int n = 0; n < 200; n++) begin
      int          kind = $urandom_range(9, 0);
      int          len  = $urandom_range(16, 1);
      logic [31:0] av   = $urandom;
      logic [31:0] bv   = $urandom;
      if (($urandom_range(3, 0)) == 0) bv = av ^ (32'd1 << $urandom_range(len - 1, 0));
      if (kind < 8) begin
        sendWord(len, av, bv, $urandom_range(2, 0));
      end else if (kind == 8) begin
        sendPartial(len, av, bv);
      end else begin
        applyStimulus(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1, 1'b0,
                      1'($urandom_range(1, 0)));
      end
      if (($urandom_range(3, 0)) == 0) idleCycle();
    end
    repeat (3) idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/bs_1_comp1.md
# bs_1_comp1

Bit-serial magnitude comparator built around a 1-bit compare cell. Operand words arrive one bit per clock, MSB first, on `a` and `b`. The block reports LT/EQ/GT for the whole word one cycle after the last bit. It sits at the compare stage of serial datapaths, where it replaces a wide parallel comparator with a single slice.

## Interface
Parameters:
- None. Word length is set at run time by the `in_first` and `in_last` framing.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a`  input  1  operand A bit, MSB first.
- `b`  input  1  operand B bit, MSB first.
- `in_valid`  input  1  `a`/`b` carry a valid bit this cycle.
- `in_first`  input  1  this beat is the MSB of a new word; qualified by `in_valid`.
- `in_last`  input  1  this beat is the LSB of the word; qualified by `in_valid`.
- `LT`  output  1  registered result: A < B.
- `EQ`  output  1  registered result: A == B.
- `GT`  output  1  registered result: A > B.
- `out_valid`  output  1  one-cycle pulse; the result registers were updated this cycle.

## Operation
- The core cell is combinational: `lt_bit = ~a & b`, `gt_bit = a & ~b`, `eq_bit = ~(a ^ b)`.
- The FSM has two states, IDLE and ACTIVE. It keeps a 2-bit accumulator {`dec_lt`, `dec_gt`}. Both bits clear means "equal so far".
- A beat is a cycle with `in_valid=1`. On a beat with `in_first`:
  - the accumulator is discarded and reloaded from the current bit's `lt_bit`/`gt_bit`;
  - the FSM enters ACTIVE.
  - This applies in either state, so a new `in_first` mid-word aborts the current word with no result output.
- On a beat in ACTIVE without `in_first`:
  - if the accumulator is still equal, it loads `lt_bit`/`gt_bit`;
  - if it is already decided, it holds. The first differing bit from the MSB decides the result.
- A beat in IDLE without `in_first` is ignored.
- On a beat with `in_last`:
  - the final decision, including the current bit, is written to `LT`/`EQ`/`GT`;
  - `out_valid` is set for one cycle;
  - the FSM returns to IDLE.
- `in_first` and `in_last` on the same beat form a one-bit word, which is a plain 1-bit compare.
- `LT`, `EQ`, `GT` are always one-hot. They hold their last result until the next word completes.
- Cycles with `in_valid=0` leave all state unchanged, so gaps inside a word are allowed.

## Timing
- Reset (`rst_n=0`, asynchronous):
  - `LT=0`, `EQ=1`, `GT=0`, `out_valid=0`;
  - FSM to IDLE, accumulator cleared.
  - Reset during a word abandons it with no output.
- Latency: the result and the `out_valid` pulse appear on the clock edge after the `in_last` beat.
- Throughput: one bit per cycle. A new `in_first` may directly follow an `in_last` beat with no idle cycle.
- `out_valid` is high for exactly one cycle per completed word. It does not assert for aborted words.

## Configuration
- `BS_COMP_SIGNED_EN` defined: words are two's complement. On the `in_first` beat the MSB sense is swapped:
  - `a=1, b=0` loads LT;
  - `a=0, b=1` loads GT.
  - All other bits compare unsigned.
- Not defined: all bits, including the MSB, compare as unsigned magnitude.

## Test plan
- One-bit words, each beat with `in_first=in_last=1`, at 10-cycle spacing (unsigned build):
  - `a=1, b=0` -> `GT=1`;
  - `a=0, b=0` -> `EQ=1`;
  - `a=0, b=1` -> `LT=1`;
  - `a=1, b=1` -> `EQ=1`;
  - each result follows with a one-cycle `out_valid`.
- Four-bit words, back to back:
  - A=1010, B=1001 -> `GT` one cycle after the LSB;
  - then A=0110, B=0110 -> `EQ`;
  - then A=0011, B=1000 -> `LT`.
- Restart: A=1100, B=0100 for two bits, then `in_first` with A=00, B=01:
  - no `out_valid` for the aborted word;
  - result `LT`.
- Reset mid-word, with `rst_n` low for 3 cycles after bit 2:
  - outputs return to `EQ=1`, `out_valid=0`;
  - the next full word compares correctly.
- Gaps: A=101, B=100 with `in_valid` low for 2 cycles between bits -> `GT`, single `out_valid`.
- With `BS_COMP_SIGNED_EN`: A=1000 (−8), B=0111 (7) -> `LT`; without the macro, the same words -> `GT`.
